// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer.
//   state_t     : controller states (WAIT_A is the same state as IDLE)
//   OP_MUL/DIV  : values of the op select
//   step_cnt_w  : width of the step counter, sized for the longer of the
//                 multiply run (2*word_length) and the divide cap
package muldiv_pkg;

  typedef enum logic [2:0] {
    IDLE, WAIT_B, ARMED, CLEAR, MUL_RUN, DIV_RUN, DONE
  } state_t;

  localparam state_t WAIT_A = IDLE;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  function automatic int step_cnt_w(input int word_length, input int div_max_steps);
    int m;
    m = (2 * word_length > div_max_steps) ? 2 * word_length : div_max_steps;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/muldiv_sequencer_edge_pulse.sv
// Rising-edge detector with a registered history bit.
//   clk, reset : clock, synchronous active-high reset
//   d          : level input
//   pulse      : d & ~d_prev, same cycle (REG_OUT=0) or one cycle later (REG_OUT=1)
// INIT is the history value forced by reset; INIT=1 keeps a level that is
// already high during reset from producing a pulse afterwards.
module edge_pulse #(
  parameter logic INIT    = 1'b0,
  parameter logic REG_OUT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic pulse
);

  logic d_q;
  logic rise;
  logic rise_q;

  assign rise  = d & ~d_q;
  assign pulse = REG_OUT ? rise_q : rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      d_q    <= INIT;
      rise_q <= 1'b0;
    end else begin
      d_q    <= d;
      rise_q <= rise;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Controller for the shared shift-add multiplier / repeated-subtraction divider.
// Two load presses capture operands A then B from one bus; start runs the
// op-selected algorithm, then ready is held in DONE.
//   inputs : clk, reset (sync, active high), load (raw button level), start,
//            op (0 mul, 1 div), div_ge (remainder >= divisor), divisor_zero
//   outputs: sel_data, en_a, en_b, load_sh, shift, clr_acc, acc_en, cnt_inc,
//            op_lat, result_en, stored, ready, busy
//            div_err (only with MULDIV_DIV_ZERO_GUARD_EN)
// Build option: define MULDIV_DIV_ZERO_GUARD_EN to short-circuit a divide by
// zero straight to DONE with div_err set; otherwise a zero divisor runs until
// the DIV_MAX_STEPS cap.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WORD_LENGTH   = 9,
  parameter int DIV_MAX_STEPS = 511
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic start,
  input  logic op,
  input  logic div_ge,
  input  logic divisor_zero,
  output logic sel_data,
  output logic en_a,
  output logic en_b,
  output logic load_sh,
  output logic shift,
  output logic clr_acc,
  output logic acc_en,
  output logic cnt_inc,
  output logic op_lat,
  output logic result_en,
  output logic stored,
  output logic ready,
  output logic busy
`ifdef MULDIV_DIV_ZERO_GUARD_EN
  ,
  output logic div_err
`endif
);

  localparam int CW = step_cnt_w(WORD_LENGTH, DIV_MAX_STEPS);
  localparam logic [CW-1:0] MUL_LAST = CW'(2 * WORD_LENGTH - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV_MAX_STEPS - 1);

  state_t          state, ns;
  logic [CW-1:0]   cnt;
  logic            load_pulse;
  logic            start_go;
  logic            zero_trap;
  logic            captured;

  edge_pulse #(.INIT(1'b1), .REG_OUT(1'b0)) u_load_edge (
    .clk(clk), .reset(reset), .d(load), .pulse(load_pulse)
  );

  // en_a/en_b are single-cycle, so a registered edge gives "stored" one cycle later
  assign captured = en_a | en_b;
  edge_pulse #(.INIT(1'b0), .REG_OUT(1'b1)) u_stored_edge (
    .clk(clk), .reset(reset), .d(captured), .pulse(stored)
  );

`ifdef MULDIV_DIV_ZERO_GUARD_EN
  assign zero_trap = (op == OP_DIV) & divisor_zero;
`else
  logic unused_divisor_zero;
  assign unused_divisor_zero = divisor_zero;
  assign zero_trap = 1'b0;
`endif

  // Strobes that must land in the same cycle as the input that causes them
  assign start_go = (state == ARMED) & start;
  assign en_a     = load_pulse & ((state == WAIT_A) | ((state == DONE) & ~start));
  assign en_b     = load_pulse & (state == WAIT_B);
  assign load_sh  = start_go & ~zero_trap;
  assign cnt_inc  = (state == DIV_RUN) & div_ge;
  assign acc_en   = shift | cnt_inc;

  always_comb begin
    ns = state;
    case (state)
      WAIT_A:  if (load_pulse) ns = WAIT_B;
      WAIT_B:  if (load_pulse) ns = ARMED;
      // start has priority over a coincident load press
      ARMED:   if (start) ns = zero_trap ? DONE : CLEAR;
               else if (load_pulse) ns = WAIT_B;
      CLEAR:   ns = (op_lat == OP_DIV) ? DIV_RUN : MUL_RUN;
      MUL_RUN: if (cnt == MUL_LAST) ns = DONE;
      // at the cap the final step still updates, then the run ends
      DIV_RUN: if (!div_ge || cnt == DIV_LAST) ns = DONE;
      DONE:    if (!start && load_pulse) ns = WAIT_B;
      default: ns = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      op_lat    <= OP_MUL;
      sel_data  <= 1'b0;
      busy      <= 1'b0;
      ready     <= 1'b0;
      clr_acc   <= 1'b0;
      shift     <= 1'b0;
      result_en <= 1'b0;
`ifdef MULDIV_DIV_ZERO_GUARD_EN
      div_err   <= 1'b0;
`endif
    end else begin
      state     <= ns;
      sel_data  <= (ns == WAIT_B) || (ns == ARMED);
      busy      <= (ns == CLEAR) || (ns == MUL_RUN) || (ns == DIV_RUN);
      ready     <= (ns == DONE);
      clr_acc   <= (ns == CLEAR);
      shift     <= (ns == MUL_RUN);
      // only a completed run captures a result, never the divide-by-zero bypass
      result_en <= (ns == DONE) && ((state == MUL_RUN) || (state == DIV_RUN));
      if (start_go) op_lat <= op;
      if (state == CLEAR) cnt <= '0;
      else if ((state == MUL_RUN) || cnt_inc) cnt <= cnt + 1'b1;
`ifdef MULDIV_DIV_ZERO_GUARD_EN
      if (start_go && zero_trap) div_err <= 1'b1;
      else if (load_pulse)       div_err <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: a behavioural datapath reacts to the controls,
// every cycle's outputs are checked against an expected timeline derived from
// operand arithmetic, and final results are pinned to literal values.
module tb_muldiv_sequencer;
  localparam int W    = 9;
  localparam int MAXS = 511;

  logic clk = 1'b0;
  logic reset, load, start, op, div_ge, divisor_zero;
  logic sel_data, en_a, en_b, load_sh, shift, clr_acc, acc_en, cnt_inc;
  logic op_lat, result_en, stored, ready, busy;
`ifdef MULDIV_DIV_ZERO_GUARD_EN
  logic div_err;
`endif

  muldiv_sequencer #(.WORD_LENGTH(W), .DIV_MAX_STEPS(MAXS)) dut (
    .clk(clk), .reset(reset), .load(load), .start(start), .op(op),
    .div_ge(div_ge), .divisor_zero(divisor_zero),
    .sel_data(sel_data), .en_a(en_a), .en_b(en_b), .load_sh(load_sh),
    .shift(shift), .clr_acc(clr_acc), .acc_en(acc_en), .cnt_inc(cnt_inc),
    .op_lat(op_lat), .result_en(result_en), .stored(stored),
    .ready(ready), .busy(busy)
`ifdef MULDIV_DIV_ZERO_GUARD_EN
    , .div_err(div_err)
`endif
  );

  always #5 clk = ~clk;

  localparam bit [12:0] SEL = 13'h1000, ENA = 13'h0800, ENB = 13'h0400, LSH = 13'h0200;
  localparam bit [12:0] SHF = 13'h0100, CLR = 13'h0080, ACC = 13'h0040, CNT = 13'h0020;
  localparam bit [12:0] OPL = 13'h0010, REN = 13'h0008, STO = 13'h0004, RDY = 13'h0002;
  localparam bit [12:0] BSY = 13'h0001;

  wire [12:0] outs = {sel_data, en_a, en_b, load_sh, shift, clr_acc, acc_en, cnt_inc,
                      op_lat, result_en, stored, ready, busy};

  // behavioural datapath driven by the controller
  logic [W-1:0]   data = '0, ra = '0, rb = '0;
  logic [2*W-1:0] mcand = '0, mplier = '0, acc = '0, rem = '0, dvsr = '0, res = '0;
  int             q = 0;

  assign div_ge       = (rem >= dvsr);
  assign divisor_zero = (rb == '0);

  always @(posedge clk) begin
    if (en_a) ra <= data;
    if (en_b) rb <= data;
    if (load_sh) begin
      mcand  <= {{W{ra[W-1]}}, ra};
      mplier <= {{W{rb[W-1]}}, rb};
      rem    <= {{W{1'b0}}, ra};
      dvsr   <= {{W{1'b0}}, rb};
    end
    if (clr_acc) begin
      acc <= '0;
      q   <= 0;
    end
    if (shift && acc_en) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end else if (acc_en) begin
      rem <= rem - dvsr;
    end
    if (cnt_inc) q <= q + 1;
    if (result_en) res <= op_lat ? (2*W)'(q) : acc;
  end

  // expected-output scoreboard, one entry per cycle
  bit [12:0] exp_q[$];
  bit [12:0] base;
  bit        sto_next;
  int        checks = 0, errors = 0;

  always @(negedge clk) begin
    bit [12:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL outs t=%0t got=%h exp=%h", $time, outs, e);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, act, expv);
    end
  endtask

  // drive one cycle and record what the outputs must be during it
  task automatic cyc(input logic ld, input logic st, input logic o, input bit [12:0] extra);
    load  = ld;
    start = st;
    op    = o;
    exp_q.push_back(base | extra | (sto_next ? STO : 13'h0));
    sto_next = (extra & (ENA | ENB)) != 13'h0;
    @(posedge clk);
    #1;
  endtask

  // from IDLE or DONE: capture A then B, ending in ARMED
  task automatic load_ab(input logic [W-1:0] a, input logic [W-1:0] b);
    data = a;
    cyc(1, 0, 0, ENA);
    base = SEL | (base & OPL);
    cyc(0, 0, 0, 13'h0);
    data = b;
    cyc(1, 0, 0, ENB);
    cyc(0, 0, 0, 13'h0);
  endtask

  // from ARMED: start an op and walk the timeline through DONE
  task automatic run(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic load_with_start);
    int n, len;
    if (o == 1'b0) begin
      n = 2 * W; len = 2 * W;
    end else begin
      n = (b == '0) ? MAXS : int'(a) / int'(b);
      if (n >= MAXS) begin n = MAXS; len = MAXS; end
      else len = n + 1;          // one extra cycle observes div_ge low
    end
    cyc(load_with_start, 1, o, LSH);
    base = (o ? OPL : 13'h0) | BSY;
    cyc(load_with_start, 0, ~o, CLR);            // op flips while busy
    for (int k = 0; k < len; k++)
      cyc(0, 0, ~o, o ? ((k < n) ? (ACC | CNT) : 13'h0) : (SHF | ACC));
    base = (o ? OPL : 13'h0) | RDY;
    cyc(0, 1, o, REN);                           // start held: no retrigger
    cyc(0, 1, o, 13'h0);
    cyc(1, 1, o, 13'h0);                         // press with start high is ignored
    cyc(0, 0, o, 13'h0);
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; start = 1'b0; op = 1'b0;
    base = 13'h0; sto_next = 1'b0;
    @(posedge clk);
    #1;
    cyc(0, 0, 0, 13'h0);
    cyc(0, 0, 0, 13'h0);
    reset = 1'b0;
    cyc(0, 0, 0, 13'h0);

    // 5 * 3
    load_ab(9'd5, 9'd3);
    run(1'b0, 9'd5, 9'd3, 1'b0);
    chk("mul_5x3", 32'(res), 32'h0000F);

    // -4 * 7 = -28 mod 2^18
    load_ab(9'h1FC, 9'd7);
    run(1'b0, 9'h1FC, 9'd7, 1'b0);
    chk("mul_m4x7", 32'(res), 32'h3FFE4);

    // 17 / 5, with B first loaded as 99 then replaced from ARMED
    load_ab(9'd17, 9'd99);
    data = 9'd5;
    cyc(1, 0, 0, 13'h0);                         // ARMED press: back to WAIT_B, no capture
    cyc(0, 0, 0, 13'h0);
    cyc(1, 0, 0, ENB);
    cyc(0, 0, 0, 13'h0);
    run(1'b1, 9'd17, 9'd5, 1'b0);
    chk("div_17_5", 32'(res), 32'd3);

    // 2 / 9: zero iterations; load pressed with start is ignored
    load_ab(9'd2, 9'd9);
    run(1'b1, 9'd2, 9'd9, 1'b1);
    chk("div_2_9", 32'(res), 32'd0);

    // reset during the 8th multiply step with the button held
    load_ab(9'd6, 9'd6);
    cyc(0, 1, 0, LSH);
    base = BSY;
    cyc(0, 0, 0, CLR);
    for (int k = 0; k < 7; k++) cyc(0, 0, 0, SHF | ACC);
    reset = 1'b1;
    cyc(1, 0, 0, SHF | ACC);
    base = 13'h0;
    cyc(1, 0, 0, 13'h0);
    cyc(1, 0, 0, 13'h0);
    reset = 1'b0;
    cyc(1, 0, 0, 13'h0);
    cyc(1, 0, 0, 13'h0);
    cyc(0, 0, 0, 13'h0);

    // divide by zero
    load_ab(9'd200, 9'd0);
`ifdef MULDIV_DIV_ZERO_GUARD_EN
    cyc(0, 1, 1, 13'h0);
    base = OPL | RDY;
    cyc(0, 0, 1, 13'h0);
    chk("div_err_set", 32'(div_err), 32'd1);
    load_ab(9'h1FD, 9'h1FB);
    chk("div_err_clr", 32'(div_err), 32'd0);
`else
    run(1'b1, 9'd200, 9'd0, 1'b0);
    chk("div_by_0_cap", 32'(res), 32'd511);
    load_ab(9'h1FD, 9'h1FB);
`endif

    // -3 * -5 = 15
    run(1'b0, 9'h1FD, 9'h1FB, 1'b0);
    chk("mul_m3xm5", 32'(res), 32'h0000F);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
